sync_fifo_thr: RTL

Parametrised single-clock FIFO, successor to the basic buffering FIFO used on the AXI burst data paths. It stores all NUM_ENTRIES words, where the previous generation stored NUM_ENTRIES-1. It adds a live occupancy count, programmable almost-full/almost-empty thresholds and pass-through when full. It also has optional sticky overflow/underflow error flags. It sits between the AXI read/write channel logic and the burst engines as the elastic data buffer.

---
 rtl/sync_fifo_pkg.sv | 9 +
 rtl/sync_fifo_ram.sv | 19 +
 rtl/sync_fifo_thr.sv | 91 +++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared sizing and pointer-wrap helpers for sync_fifo_thr.
package sync_fifo_pkg;
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned n);
    return (ptr == n - 1) ? 32'd0 : ptr + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: 1-write / 1-async-read storage array, swappable for a registered-read macro.
module sync_fifo_ram #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned NUM_ENTRIES = 64,
  localparam int unsigned AW = $clog2(NUM_ENTRIES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [NUM_ENTRIES];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_thr.sv
// sync_fifo_thr: FWFT single-clock FIFO with occupancy count, thresholds and pass-through when full.
// Define SYNC_FIFO_ERR_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module sync_fifo_thr
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned NUM_ENTRIES = 64,
  parameter int unsigned AF_THRESH = NUM_ENTRIES - 4,
  parameter int unsigned AE_THRESH = 4,
  localparam int unsigned CW = cnt_w(NUM_ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow
);
  localparam int unsigned PW = $clog2(NUM_ENTRIES);
  localparam logic [CW-1:0] N_C = CW'(NUM_ENTRIES);
  localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C = CW'(AE_THRESH);
  if (NUM_ENTRIES < 2) begin : g_bad_depth
    $error("sync_fifo_thr: NUM_ENTRIES must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > NUM_ENTRIES) begin : g_bad_af
    $error("sync_fifo_thr: AF_THRESH must be in 1..NUM_ENTRIES");
  end
  if (AE_THRESH >= NUM_ENTRIES) begin : g_bad_ae
    $error("sync_fifo_thr: AE_THRESH must be below NUM_ENTRIES");
  end
  logic [PW-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic wr_acc, rd_acc;
  // a full FIFO still takes a write when the head is popped on the same edge
  always_comb begin
    wr_acc = wr_en && (!full || rd_en);
    rd_acc = rd_en && !empty;
    w_ptr_d = wr_acc ? PW'(ptr_inc(32'(w_ptr_q), NUM_ENTRIES)) : w_ptr_q;
    r_ptr_d = rd_acc ? PW'(ptr_inc(32'(r_ptr_q), NUM_ENTRIES)) : r_ptr_q;
    count_d = (wr_acc && !rd_acc) ? count_q + 1'b1 :
              (rd_acc && !wr_acc) ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
    end
  end
  assign count        = count_q;
  assign full         = count_q == N_C;
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= AF_C;
  assign almost_empty = count_q <= AE_C;
`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  always_comb begin
    overflow_d  = overflow_q || (wr_en && !wr_acc);
    underflow_d = underflow_q || (rd_en && empty);
  end
  always_ff @(posedge clk) begin
    overflow_q  <= reset ? 1'b0 : overflow_d;
    underflow_q <= reset ? 1'b0 : underflow_d;
  end
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif
  sync_fifo_ram #(.DATA_W(DATA_W), .NUM_ENTRIES(NUM_ENTRIES)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (w_ptr_q),
    .wdata (din),
    .raddr (r_ptr_q),
    .rdata (dout)
  );
endmodule
